// File: rtl/bankp_clk_rst_gen_if.sv
// Control/status bundle between the clock/reset generator and its user.
// The master side drives the lock, reset and pause requests. The slave side
// (the generator) drives the clock enables and the core reset.
interface bankp_clk_rst_gen_if;
  logic pll_locked;
  logic soft_reset;
  logic pause;
  logic ce_mst;
  logic ce_pix;
  logic ce_cpu;
  logic core_rst_n;
  logic running;

  modport master (
    output pll_locked, soft_reset, pause,
    input  ce_mst, ce_pix, ce_cpu, core_rst_n, running
  );

  modport slave (
    input  pll_locked, soft_reset, pause,
    output ce_mst, ce_pix, ce_cpu, core_rst_n, running
  );
endinterface

// File: rtl/bankp_clk_rst_gen.sv
// Clock-enable and core-reset generator behind the 36 MHz system PLL.
// A fractional accumulator produces the master enable, which averages
// ACC_NUM/ACC_DEN pulses per clk_sys cycle. Pixel and CPU enables are
// derived from it by integer division. The core reset is held until PLL lock
// has been stable for HOLD_CYC cycles.
//
// state  | meaning
// S_WAIT | no lock: core in reset, accumulator/dividers cleared, no enables
// S_HOLD | locked: enables running, core still in reset, hold_cnt counting
// S_RUN  | core out of reset, running=1
module bankp_clk_rst_gen #(
  parameter int unsigned ACC_NUM  = 15468,
  parameter int unsigned ACC_DEN  = 36000,
  parameter int unsigned PIX_DIV  = 3,
  parameter int unsigned CPU_DIV  = 6,
  parameter int unsigned HOLD_CYC = 1024
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  bankp_clk_rst_gen_if.slave   bus
);

  localparam int unsigned PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned CPU_W = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_DIV - 1);
  localparam logic [CPU_W-1:0] CPU_LAST  = CPU_W'(CPU_DIV - 1);
  localparam logic [15:0]      HOLD_LAST = 16'(HOLD_CYC - 1);
  localparam logic [16:0]      NUM17     = 17'(ACC_NUM);
  localparam logic [16:0]      DEN17     = 17'(ACC_DEN);

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_RUN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         lock_sync;
  logic               lock_s;
  logic [15:0]        acc;
  logic [15:0]        acc_nxt;
  logic [16:0]        acc_sum;
  logic               ovf;
  logic [15:0]        hold_cnt;
  logic [PIX_W-1:0]   pix_cnt;
  logic [CPU_W-1:0]   cpu_cnt;
  logic               ce_mst_q;
  logic               ce_pix_q;
  logic               ce_cpu_q;
  logic               core_rst_n_q;
  logic               running_q;

  assign lock_s = lock_sync[1];

  // Fractional accumulator step; a wrap past ACC_DEN is one master tick.
  always_comb begin
    acc_sum = {1'b0, acc} + NUM17;
    ovf     = (acc_sum >= DEN17);
    acc_nxt = ovf ? 16'(acc_sum - DEN17) : acc_sum[15:0];
  end

  // Next-state decode: lock loss wins over soft reset, which restarts the hold.
  always_comb begin
    state_nxt = state;
    if (!lock_s) begin
      state_nxt = S_WAIT;
    end else if (bus.soft_reset && (state != S_WAIT)) begin
      state_nxt = S_HOLD;
    end else begin
      case (state)
        S_WAIT:  state_nxt = S_HOLD;
        S_HOLD:  state_nxt = (hold_cnt == HOLD_LAST) ? S_RUN : S_HOLD;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_WAIT;
      endcase
    end
  end

  // Lock synchroniser, FSM, hold timer, accumulator, dividers and registered
  // outputs. Everything is keyed to the next state so that enables stop and
  // the counters clear in the same cycle that core_rst_n falls.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync    <= 2'b00;
      state        <= S_WAIT;
      hold_cnt     <= 16'd0;
      acc          <= 16'd0;
      pix_cnt      <= '0;
      cpu_cnt      <= '0;
      ce_mst_q     <= 1'b0;
      ce_pix_q     <= 1'b0;
      ce_cpu_q     <= 1'b0;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      lock_sync    <= {lock_sync[0], bus.pll_locked};
      state        <= state_nxt;
      core_rst_n_q <= (state_nxt == S_RUN);
      running_q    <= (state_nxt == S_RUN);

      if ((state == S_HOLD) && (state_nxt == S_HOLD) && !bus.soft_reset)
        hold_cnt <= hold_cnt + 16'd1;
      else
        hold_cnt <= 16'd0;

      if (state_nxt == S_WAIT) begin
        acc      <= 16'd0;
        pix_cnt  <= '0;
        cpu_cnt  <= '0;
        ce_mst_q <= 1'b0;
        ce_pix_q <= 1'b0;
        ce_cpu_q <= 1'b0;
      end else begin
        acc      <= acc_nxt;
        ce_mst_q <= ovf;
        ce_pix_q <= ovf && (pix_cnt == PIX_LAST);
        // Pause only masks the CPU enable; its divider keeps phase.
        ce_cpu_q <= ovf && (cpu_cnt == CPU_LAST) && !bus.pause;
        if (ovf) begin
          pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
          cpu_cnt <= (cpu_cnt == CPU_LAST) ? '0 : cpu_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.ce_mst     = ce_mst_q;
  assign bus.ce_pix     = ce_pix_q;
  assign bus.ce_cpu     = ce_cpu_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.running    = running_q;

endmodule

// File: tb/tb_bankp_clk_rst_gen.sv
// Directed bench for bankp_clk_rst_gen with default parameters.
module tb_bankp_clk_rst_gen;

  localparam int HOLD = 1024;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b1;

  bankp_clk_rst_gen_if bus ();

  bankp_clk_rst_gen dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  logic [4:0] outs;
  assign outs = {bus.ce_mst, bus.ce_pix, bus.ce_cpu, bus.core_rst_n, bus.running};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Cadence monitor: every 3rd master pulse since lock must carry ce_pix,
  // every 6th ce_cpu unless pause was high at that edge.
  logic mon_clear  = 1'b1;
  int   mon_n      = 0;
  int   align_err  = 0;
  int   adj_err    = 0;
  logic prev_mst   = 1'b0;
  logic pause_last = 1'b0;
  logic exp_pix, exp_cpu;

  always @(negedge clk_sys) begin
    if (mon_clear) begin
      mon_n    = 0;
      prev_mst = 1'b0;
    end else begin
      if (bus.ce_mst && prev_mst) adj_err++;
      if (bus.ce_mst) mon_n++;
      exp_pix = bus.ce_mst && (mon_n % 3 == 0);
      exp_cpu = bus.ce_mst && (mon_n % 6 == 0) && !pause_last;
      if ((bus.ce_pix !== exp_pix) || (bus.ce_cpu !== exp_cpu)) align_err++;
      prev_mst = bus.ce_mst;
    end
    pause_last = bus.pause;
  end

  typedef struct {
    logic       pll;
    logic       srst;
    logic       pause;
    logic [4:0] exp;   // {ce_mst, ce_pix, ce_cpu, core_rst_n, running}
  } vec_t;

  vec_t tbl [19];

  int cnt_mst, cnt_pix, cnt_cpu, early, first_mst, first_rst, run_mis, lows, kfound;
  logic bad, done;

  initial begin
    // Row k: inputs applied before edge k, outputs expected after edge k.
    // Accumulator from 0 wraps on evaluations 3,5,7,10,12,14 (edges 5,7,9,12,14,16).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 5'b00000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'b11000};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 5'b00000};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 5'b11100};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 5'b00000};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 5'b00000}; // would wrap, but lock loss reaches WAIT

    bus.pll_locked = 1'b0;
    bus.soft_reset = 1'b0;
    bus.pause      = 1'b0;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset_outs", {27'd0, outs}, 32'd0);

    // Table: first cycles after reset release with lock.
    rst_n = 1'b1;
    bus.pll_locked = tbl[0].pll; bus.soft_reset = tbl[0].srst; bus.pause = tbl[0].pause;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk_sys); #1;
      check($sformatf("vec%0d", i + 1), {27'd0, outs}, {27'd0, tbl[i].exp});
      if (i < 18) begin
        bus.pll_locked = tbl[i+1].pll;
        bus.soft_reset = tbl[i+1].srst;
        bus.pause      = tbl[i+1].pause;
      end
    end
    bus.soft_reset = 1'b0;
    bus.pause      = 1'b0;

    // Release timing plus a full ACC_DEN window from S_HOLD entry.
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1 mon_clear = 1'b0;
    @(posedge clk_sys); #1;
    rst_n = 1'b1;
    bus.pll_locked = 1'b1;
    cnt_mst = 0; cnt_pix = 0; cnt_cpu = 0; early = 0;
    first_mst = 0; first_rst = 0; run_mis = 0;
    for (int k = 1; k <= 36002; k++) begin
      @(posedge clk_sys); #1;
      if (k >= 3) begin
        cnt_mst += int'(bus.ce_mst);
        cnt_pix += int'(bus.ce_pix);
        cnt_cpu += int'(bus.ce_cpu);
      end else begin
        early += int'(bus.ce_mst | bus.ce_pix | bus.ce_cpu);
      end
      if (bus.ce_mst && first_mst == 0) first_mst = k;
      if (bus.core_rst_n && first_rst == 0) first_rst = k;
      if (bus.core_rst_n !== bus.running) run_mis++;
    end
    check("release_cycle", first_rst, 3 + HOLD);
    check("running_with_rst", run_mis, 0);
    check("no_enables_before_hold", early, 0);
    check("first_mst_cycle", first_mst, 5);
    check("window_mst", cnt_mst, 15468);
    check("window_pix", cnt_pix, 5156);
    check("window_cpu", cnt_cpu, 2578);

    // Pause in S_RUN.
    bus.pause = 1'b1;
    cnt_mst = 0; cnt_pix = 0; cnt_cpu = 0;
    repeat (6000) begin
      @(posedge clk_sys); #1;
      cnt_mst += int'(bus.ce_mst);
      cnt_pix += int'(bus.ce_pix);
      cnt_cpu += int'(bus.ce_cpu);
    end
    bus.pause = 1'b0;
    check("pause_cpu", cnt_cpu, 0);
    check("pause_mst", cnt_mst, 2578);
    check("pause_pix", {31'd0, (cnt_pix == 859 || cnt_pix == 860)}, 1);
    cnt_cpu = 0;
    repeat (600) begin
      @(posedge clk_sys); #1;
      cnt_cpu += int'(bus.ce_cpu);
    end
    check("unpause_cpu", {31'd0, (cnt_cpu == 42 || cnt_cpu == 43)}, 1);

    // Lock loss in S_RUN and relock.
    bus.pll_locked = 1'b0;
    @(posedge clk_sys); #1;
    check("lockloss_e1", {31'd0, bus.core_rst_n}, 1);
    @(posedge clk_sys); #1;
    check("lockloss_e2", {31'd0, bus.core_rst_n}, 1);
    @(posedge clk_sys); #1;
    check("lockloss_e3", {27'd0, outs}, 0);
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk_sys); #1;
      if (outs != 5'd0) bad = 1'b1;
    end
    check("wait_quiet", {31'd0, bad}, 0);
    mon_clear = 1'b1;
    @(negedge clk_sys); #1;
    mon_clear = 1'b0;
    @(posedge clk_sys); #1;
    bus.pll_locked = 1'b1;
    kfound = 0;
    for (int k = 1; k <= 3 + HOLD + 20 && kfound == 0; k++) begin
      @(posedge clk_sys); #1;
      if (bus.core_rst_n) kfound = k;
    end
    check("relock_release", kfound, 3 + HOLD);

    // Soft reset pulse in S_RUN.
    repeat (50) @(posedge clk_sys);
    #1 bus.soft_reset = 1'b1;
    @(posedge clk_sys); #1;
    bus.soft_reset = 1'b0;
    lows = 0; cnt_pix = 0; done = 1'b0;
    for (int k = 0; k < HOLD + 20 && !done; k++) begin
      if (bus.core_rst_n) done = 1'b1;
      else begin
        lows++;
        cnt_pix += int'(bus.ce_pix);
        @(posedge clk_sys); #1;
      end
    end
    check("soft_reset_low_cycles", lows, HOLD);
    check("soft_reset_pix", {31'd0, (cnt_pix == 146 || cnt_pix == 147)}, 1);

    check("cadence_alignment", align_err, 0);
    check("mst_never_adjacent", adj_err, 0);

    // Asynchronous reset mid-HOLD, on a cycle where ce_mst is high.
    #1 bus.soft_reset = 1'b1;
    @(posedge clk_sys); #1;
    bus.soft_reset = 1'b0;
    repeat (100) @(posedge clk_sys);
    #1;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(posedge clk_sys); #1;
      if (bus.ce_mst) done = 1'b1;
    end
    check("found_mst_in_hold", {31'd0, done}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", {27'd0, outs}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
